// File: rtl/bram_port_arbiter.sv
// Single BRAM port shared by pipeline A (absolute priority, 1-cycle read) and master B (2-deep in-order FIFO, b_ready from count only).
// Blocked-cycle counter CSR at STATS_ADDR exists only when BRAM_ARB_STATS_EN is defined.
module bram_port_arbiter #(
    parameter int unsigned ADDR_W     = 14,
    parameter logic [11:0] STATS_ADDR = 12'h7c2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              a_valid,
    input  logic              a_write,
    input  logic [3:0]        a_wmask,
    input  logic [31:0]       a_wdata,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [31:0]       a_rdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_write,
    input  logic [3:0]        b_wmask,
    input  logic [31:0]       b_wdata,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_rvalid,
    output logic [31:0]       b_rdata,
    output logic              m_write,
    output logic [3:0]        m_wmask,
    output logic [31:0]       m_wdata,
    output logic [ADDR_W-1:0] m_addr,
    input  logic [31:0]       m_rdata,
    input  logic              csr_read,
    input  logic [1:0]        csr_modify,
    input  logic [31:0]       csr_wdata,
    input  logic [11:0]       csr_addr,
    output logic [31:0]       csr_rdata,
    output logic              csr_valid
);
    typedef struct packed {
        logic              write;
        logic [3:0]        wmask;
        logic [31:0]       wdata;
        logic [ADDR_W-1:0] addr;
    } req_t;

    req_t        fifo_mem [2];
    req_t        head;
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic        a_active;
    logic        push;
    logic        pop;
    logic        rd_pend;
    logic [31:0] rdata_hold;

    assign a_active = a_valid | a_write;
    assign head     = fifo_mem[rd_ptr];
    assign b_ready  = (count < 2'd2);
    assign push     = b_valid & b_ready;
    assign pop      = ~a_active & (count != 2'd0);

    assign a_rdata  = m_rdata;
    assign b_rvalid = rd_pend;
    assign b_rdata  = rd_pend ? m_rdata : rdata_hold;

    always_comb begin
        m_write = 1'b0;
        m_wmask = 4'b0000;
        m_wdata = a_wdata;
        m_addr  = a_addr;
        if (a_active) begin
            m_write = a_write;
            m_wmask = a_wmask;
        end else if (count != 2'd0) begin
            m_write = head.write;
            m_wmask = head.wmask;
            m_wdata = head.wdata;
            m_addr  = head.addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_pend    <= 1'b0;
            rdata_hold <= 32'h0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count   <= count + {1'b0, push} - {1'b0, pop};
            rd_pend <= pop & ~head.write;
            // Capture the returned word so b_rdata holds it after the pulse.
            if (rd_pend) rdata_hold <= m_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {b_write, b_wmask, b_wdata, b_addr};
    end

`ifdef BRAM_ARB_STATS_EN
    logic [31:0] stat_cnt;
    logic        csr_hit;
    logic        unused_csr_read;

    assign csr_hit         = (csr_addr == STATS_ADDR);
    assign unused_csr_read = csr_read;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_cnt  <= 32'h0;
            csr_valid <= 1'b0;
            csr_rdata <= 32'h0;
        end else begin
            // Software modify takes precedence over a same-cycle increment.
            if (csr_hit && csr_modify != 2'b00) begin
                case (csr_modify)
                    2'b01:   stat_cnt <= csr_wdata;
                    2'b10:   stat_cnt <= stat_cnt | csr_wdata;
                    default: stat_cnt <= stat_cnt & ~csr_wdata;
                endcase
            end else if (a_active && count != 2'd0 && stat_cnt != 32'hFFFF_FFFF) begin
                stat_cnt <= stat_cnt + 32'd1;
            end
            csr_valid <= csr_hit;
            csr_rdata <= csr_hit ? stat_cnt : 32'h0;
        end
    end
`else
    logic unused_csr;

    assign unused_csr = ^{csr_read, csr_modify, csr_wdata, csr_addr};
    assign csr_valid  = 1'b0;
    assign csr_rdata  = 32'h0;
`endif
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: BRAM model, queue-based reference model checked every cycle, directed and random stimulus.
module tb_bram_port_arbiter;
    localparam int unsigned ADDR_W     = 14;
    localparam logic [11:0] STATS_ADDR = 12'h7c2;
`ifdef BRAM_ARB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic              clk;
    logic              rstn;
    logic              a_valid, a_write;
    logic [3:0]        a_wmask;
    logic [31:0]       a_wdata;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_rdata;
    logic              b_valid, b_ready, b_write;
    logic [3:0]        b_wmask;
    logic [31:0]       b_wdata;
    logic [ADDR_W-1:0] b_addr;
    logic              b_rvalid;
    logic [31:0]       b_rdata;
    logic              m_write;
    logic [3:0]        m_wmask;
    logic [31:0]       m_wdata;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_rdata;
    logic              csr_read;
    logic [1:0]        csr_modify;
    logic [31:0]       csr_wdata;
    logic [11:0]       csr_addr;
    logic [31:0]       csr_rdata;
    logic              csr_valid;

    bram_port_arbiter #(.ADDR_W(ADDR_W), .STATS_ADDR(STATS_ADDR)) dut (
        .clk(clk), .rstn(rstn),
        .a_valid(a_valid), .a_write(a_write), .a_wmask(a_wmask), .a_wdata(a_wdata),
        .a_addr(a_addr), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_write(b_write), .b_wmask(b_wmask),
        .b_wdata(b_wdata), .b_addr(b_addr), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .m_write(m_write), .m_wmask(m_wmask), .m_wdata(m_wdata), .m_addr(m_addr),
        .m_rdata(m_rdata),
        .csr_read(csr_read), .csr_modify(csr_modify), .csr_wdata(csr_wdata),
        .csr_addr(csr_addr), .csr_rdata(csr_rdata), .csr_valid(csr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    // BRAM with registered read; preload port lets the bench seed contents.
    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [31:0]       pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (m_write) mem[m_addr] <= merge(mem[m_addr], m_wdata, m_wmask);
        m_rdata <= mem[m_addr];
    end

    // Reference model state.
    typedef struct {
        logic              w;
        logic [3:0]        m;
        logic [31:0]       d;
        logic [ADDR_W-1:0] a;
    } breq_t;

    logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
    breq_t       q [$];
    breq_t       h;
    int          occ;
    logic        act;
    logic        hit;
    logic        nxt_rv = 1'b0;
    logic [31:0] nxt_bd = 32'h0;
    logic [31:0] cur_bd = 32'h0;
    logic        nxt_ard_v = 1'b0;
    logic [31:0] nxt_ard = 32'h0;
    logic [31:0] cnt = 32'h0;
    logic        nxt_cv = 1'b0;
    logic [31:0] nxt_cr = 32'h0;

    always @(negedge clk) begin
        if (!rstn) begin
            q.delete();
            nxt_rv    = 1'b0;
            cur_bd    = 32'h0;
            nxt_ard_v = 1'b0;
            cnt       = 32'h0;
            nxt_cv    = 1'b0;
            nxt_cr    = 32'h0;
            if (a_write) ref_mem[a_addr] = merge(ref_mem[a_addr], a_wdata, a_wmask);
        end else begin
            if (nxt_rv) cur_bd = nxt_bd;
            occ = q.size();
            act = a_valid | a_write;
            chk("b_ready", b_ready, 32'(occ < 2));
            chk("b_rvalid", b_rvalid, nxt_rv);
            chk("b_rdata", b_rdata, cur_bd);
            if (nxt_ard_v) chk("a_rdata", a_rdata, nxt_ard);
            chk("csr_valid", csr_valid, nxt_cv);
            chk("csr_rdata", csr_rdata, nxt_cr);

            nxt_rv    = 1'b0;
            nxt_ard_v = 1'b0;
            if (act) begin
                chk("m_write_a", m_write, a_write);
                chk("m_wmask_a", m_wmask, a_wmask);
                chk("m_wdata_a", m_wdata, a_wdata);
                chk("m_addr_a", m_addr, a_addr);
                if (a_write) ref_mem[a_addr] = merge(ref_mem[a_addr], a_wdata, a_wmask);
                else begin
                    nxt_ard_v = 1'b1;
                    nxt_ard   = ref_mem[a_addr];
                end
            end else if (occ > 0) begin
                h = q.pop_front();
                chk("m_write_b", m_write, h.w);
                chk("m_wmask_b", m_wmask, h.m);
                chk("m_wdata_b", m_wdata, h.d);
                chk("m_addr_b", m_addr, h.a);
                if (h.w) ref_mem[h.a] = merge(ref_mem[h.a], h.d, h.m);
                else begin
                    nxt_rv = 1'b1;
                    nxt_bd = ref_mem[h.a];
                end
            end else begin
                chk("m_write_idle", m_write, 0);
                chk("m_wmask_idle", m_wmask, 0);
                chk("m_addr_idle", m_addr, a_addr);
            end
            if (b_valid && occ < 2) q.push_back('{b_write, b_wmask, b_wdata, b_addr});

            hit    = STATS_ON && (csr_addr == STATS_ADDR);
            nxt_cv = hit;
            nxt_cr = hit ? cnt : 32'h0;
            if (hit && csr_modify == 2'b01)      cnt = csr_wdata;
            else if (hit && csr_modify == 2'b10) cnt = cnt | csr_wdata;
            else if (hit && csr_modify == 2'b11) cnt = cnt & ~csr_wdata;
            else if (act && occ > 0 && cnt != 32'hFFFF_FFFF) cnt = cnt + 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_valid = 0; a_write = 0; a_wmask = 0; a_wdata = 0; a_addr = 0;
        b_valid = 0; b_write = 0; b_wmask = 0; b_wdata = 0; b_addr = 0;
        csr_read = 0; csr_modify = 0; csr_wdata = 0; csr_addr = 0;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        pl_en = 1; pl_addr = a; pl_data = d;
        ref_mem[a] = d;
        cyc();
        pl_en = 0;
    endtask

    task automatic csr_op(input logic [1:0] op, input logic [31:0] wd);
        csr_addr = STATS_ADDR; csr_modify = op; csr_wdata = wd; csr_read = (op == 2'b00);
        @(negedge clk);
        cyc();
        csr_addr = 0; csr_modify = 0; csr_wdata = 0; csr_read = 0;
    endtask

    task automatic csr_expect(input string name, input logic [31:0] exp);
        @(negedge clk);
        chk({name, "_valid"}, csr_valid, STATS_ON);
        chk(name, csr_rdata, STATS_ON ? exp : 32'h0);
        cyc();
    endtask

    logic got;

    initial begin
        rstn = 0; pl_en = 0; pl_addr = 0; pl_data = 0;
        idle();
        a_valid = 1;
        cyc();
        for (int i = 0; i < 64; i++) preload(ADDR_W'(i), 32'h0);
        rstn = 1; a_valid = 0;
        @(negedge clk);
        chk("rst_b_ready", b_ready, 1);
        chk("rst_b_rvalid", b_rvalid, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_csr_valid", csr_valid, 0);
        chk("rst_csr_rdata", csr_rdata, 0);
        cyc();

        // Minimum B read latency.
        preload(14'h3F80, 32'h1234_5678);
        b_valid = 1; b_write = 0; b_addr = 14'h3F80;
        @(negedge clk); chk("t1_accept", b_ready, 1); cyc();
        b_valid = 0;
        @(negedge clk); chk("t1_m_addr", m_addr, 32'h3F80); chk("t1_no_rvalid", b_rvalid, 0); cyc();
        @(negedge clk); chk("t1_rvalid", b_rvalid, 1); chk("t1_rdata", b_rdata, 32'h1234_5678); cyc();
        @(negedge clk); chk("t1_rvalid_off", b_rvalid, 0); chk("t1_hold", b_rdata, 32'h1234_5678); cyc();

        // B write held off by 10 A reads.
        b_valid = 1; b_write = 1; b_addr = 14'h100; b_wdata = 32'hA5A5_A5A5; b_wmask = 4'hF;
        @(negedge clk); chk("t2_accept", b_ready, 1); cyc();
        b_valid = 0;
        for (int i = 0; i < 10; i++) begin
            a_valid = 1; a_addr = ADDR_W'(i);
            @(negedge clk); chk("t2_no_b_write", m_write, 0); cyc();
        end
        a_valid = 0;
        @(negedge clk); chk("t2_issue_wr", m_write, 1); chk("t2_issue_addr", m_addr, 32'h100); cyc();
        csr_op(2'b00, 0);
        csr_expect("t2_stats", 32'd10);

        // FIFO fills while A is active, then drains in order.
        a_valid = 1; a_addr = 3;
        b_valid = 1; b_write = 1; b_addr = 14'h10; b_wdata = 32'h0BAD_F00D; b_wmask = 4'hF;
        @(negedge clk); chk("t3_rdy0", b_ready, 1); cyc();
        b_write = 0; b_addr = 14'h10;
        @(negedge clk); chk("t3_rdy1", b_ready, 1); cyc();
        b_write = 1; b_addr = 14'h11; b_wdata = 32'hCAFE_0001; b_wmask = 4'h3;
        @(negedge clk); chk("t3_full", b_ready, 0); cyc();
        a_valid = 0;
        @(negedge clk); chk("t3_full_pop", b_ready, 0); chk("t3_pop0_addr", m_addr, 32'h10);
        chk("t3_pop0_wr", m_write, 1); cyc();
        @(negedge clk); chk("t3_rdy_back", b_ready, 1); chk("t3_pop1_addr", m_addr, 32'h10);
        chk("t3_pop1_rd", m_write, 0); cyc();
        b_valid = 0;
        @(negedge clk); chk("t3_pop2_addr", m_addr, 32'h11); chk("t3_pop2_wr", m_write, 1);
        chk("t3_raw_rvalid", b_rvalid, 1); chk("t3_raw_rdata", b_rdata, 32'h0BAD_F00D); cyc();

        // Masked write then read-back.
        preload(14'd5, 32'h1122_3344);
        b_valid = 1; b_write = 1; b_addr = 14'd5; b_wdata = 32'hDEAD_BEEF; b_wmask = 4'b0101;
        @(negedge clk); chk("t4_acc_w", b_ready, 1); cyc();
        b_write = 0;
        @(negedge clk); chk("t4_acc_r", b_ready, 1); cyc();
        b_valid = 0;
        got = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (b_rvalid) begin
                got = 1;
                chk("t4_rdata", b_rdata, 32'h11AD_33EF);
            end
            cyc();
        end
        chk("t4_rvalid_seen", got, 1);

        // Reset with two reads pending.
        a_valid = 1; a_addr = 7;
        b_valid = 1; b_write = 0; b_addr = 14'h20;
        @(negedge clk); cyc();
        b_addr = 14'h21;
        @(negedge clk); cyc();
        b_valid = 0; rstn = 0;
        @(negedge clk); cyc();
        rstn = 1; a_valid = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("t5_no_rvalid", b_rvalid, 0); chk("t5_ready", b_ready, 1); cyc();
        end
        csr_op(2'b00, 0);
        csr_expect("t5_stats", 32'd0);

        // CSR modify operations, saturation, modify-wins.
        csr_op(2'b01, 32'd7);   csr_op(2'b00, 0); csr_expect("t6_write7", 32'd7);
        csr_op(2'b11, 32'h3);   csr_op(2'b00, 0); csr_expect("t6_clear3", 32'd4);
        csr_op(2'b01, 32'h0);   csr_op(2'b00, 0); csr_expect("t6_write0", 32'd0);
        csr_op(2'b10, 32'h30);  csr_op(2'b00, 0); csr_expect("t6_set", 32'h30);
        csr_op(2'b01, 32'hFFFF_FFFF);
        a_valid = 1; a_addr = 9;
        b_valid = 1; b_write = 0; b_addr = 14'h30;
        @(negedge clk); cyc();
        b_valid = 0;
        @(negedge clk); cyc();
        @(negedge clk); cyc();
        csr_op(2'b00, 0); csr_expect("t6_saturate", 32'hFFFF_FFFF);
        csr_op(2'b01, 32'd5); csr_op(2'b00, 0); csr_expect("t6_modify_wins", 32'd5);
        a_valid = 0;
        @(negedge clk); cyc();
        @(negedge clk); cyc();

        // Randomised traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            a_valid    = ($urandom_range(0, 9) < 4);
            a_write    = ($urandom_range(0, 9) == 0);
            a_addr     = ADDR_W'($urandom_range(0, 15));
            a_wdata    = $urandom;
            a_wmask    = 4'($urandom);
            b_valid    = ($urandom_range(0, 1) == 1);
            b_write    = ($urandom_range(0, 2) == 0);
            b_addr     = ADDR_W'($urandom_range(0, 15));
            b_wdata    = $urandom;
            b_wmask    = 4'($urandom);
            csr_addr   = ($urandom_range(0, 7) == 0) ? STATS_ADDR : 12'($urandom);
            csr_modify = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
            csr_wdata  = $urandom;
            csr_read   = ($urandom_range(0, 1) == 1);
            rstn       = ($urandom_range(0, 499) != 0);
            if (!rstn) begin
                a_valid = 1;
                a_write = 0;
            end
            @(negedge clk);
            cyc();
        end
        rstn = 1;
        idle();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
